// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg : shared types and constants for the calculator datapath  |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
package calc_pkg;

  localparam int FACT_WIDTH = 28;
  localparam int FACT_MAX_N = 11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/factorial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | factorial : iterative n! by repeated multiply, flags out-of-range  |
// | Rev 1.0   : initial release                                        |
// +--------------------------------------------------------------------+
module factorial
  import calc_pkg::*;
#(
  parameter int WIDTH = FACT_WIDTH,
  parameter int MAX_N = FACT_MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n,
  input  logic             valid_in,
  output logic             valid_out,
  output logic             ovrflow,
  output logic [WIDTH-1:0] d_out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             valid_out_q, valid_out_d;
  logic             ovrflow_q, ovrflow_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;

  logic             accept;
  logic [WIDTH-1:0] prod;

  always_comb begin
    accept      = (state_q == IDLE) && valid_in && armed_q;
    prod        = acc_q * WIDTH'(cnt_q);
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    valid_out_d = 1'b0;
    ovrflow_d   = ovrflow_q;
    d_out_d     = d_out_q;

    // Re-arm only after the source drops its request, so a held level starts one job.
    if (!valid_in) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (n[WIDTH-1] || (n > WIDTH'(MAX_N))) begin
            ovrflow_d   = 1'b1;
            d_out_d     = '0;
            valid_out_d = 1'b1;
          end else if (n <= WIDTH'(1)) begin
            ovrflow_d   = 1'b0;
            d_out_d     = WIDTH'(1);
            valid_out_d = 1'b1;
          end else begin
            acc_d   = WIDTH'(1);
            cnt_d   = n[3:0];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = prod;
        cnt_d = cnt_q - 4'd1;
        // The final multiply by 2 goes straight to the output register.
        if (cnt_q == 4'd2) begin
          d_out_d     = prod;
          ovrflow_d   = 1'b0;
          valid_out_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_q <= 1'b0;
      ovrflow_q   <= 1'b0;
      d_out_q     <= '0;
    end else begin
      valid_out_q <= valid_out_d;
      ovrflow_q   <= ovrflow_d;
      d_out_q     <= d_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign ovrflow   = ovrflow_q;
  assign d_out     = d_out_q;

endmodule
`default_nettype wire

// File: tb/tb_factorial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_factorial : directed self-checking bench for factorial          |
// | Rev 1.0      : initial release                                     |
// +--------------------------------------------------------------------+
module tb_factorial;

  logic        clk;
  logic        rst;
  logic [27:0] n;
  logic        valid_in;
  logic        valid_out;
  logic        ovrflow;
  logic [27:0] d_out;

  int tests = 0;
  int fails = 0;

  factorial dut (
    .clk       (clk),
    .rst       (rst),
    .n         (n),
    .valid_in  (valid_in),
    .valid_out (valid_out),
    .ovrflow   (ovrflow),
    .d_out     (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic run_op(input string tag, input logic [27:0] nv, input int hold,
                        input int exp_lat, input logic [27:0] exp_d, input logic exp_ov);
    int edges;
    int extra;
    bit seen;
    n        = nv;
    valid_in = 1'b1;
    edges    = 0;
    seen     = 1'b0;
    while (!seen && edges < 40) begin
      step();
      edges++;
      if (edges == hold) valid_in = 1'b0;
      if (valid_out) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(edges), 32'(exp_lat));
    check({tag, "_dout"}, 32'(d_out), 32'(exp_d));
    check({tag, "_ovf"}, 32'(ovrflow), 32'(exp_ov));
    extra = 0;
    while (edges < hold) begin
      step();
      edges++;
      if (edges == hold) valid_in = 1'b0;
      if (valid_out) extra++;
    end
    repeat (4) begin
      step();
      if (valid_out) extra++;
    end
    check({tag, "_nodup"}, 32'(extra), 32'd0);
    check({tag, "_hold"}, 32'(d_out), 32'(exp_d));
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    valid_in = 1'b0;
    n        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ovf", 32'(ovrflow), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    rst = 1'b0;
    step();

    run_op("n5",   28'd5,         3, 5,  28'd120,      1'b0);
    run_op("n8",   28'd8,         1, 8,  28'd40320,    1'b0);
    run_op("n4",   28'd4,         2, 4,  28'd24,       1'b0);
    run_op("n2",   28'd2,         1, 2,  28'd2,        1'b0);
    run_op("n0",   28'd0,         3, 1,  28'd1,        1'b0);
    run_op("n1",   28'd1,         1, 1,  28'd1,        1'b0);
    run_op("nm2",  28'hFFFFFFE,   3, 1,  28'd0,        1'b1);
    run_op("n12",  28'd12,        1, 1,  28'd0,        1'b1);
    run_op("n45",  28'd45,        2, 1,  28'd0,        1'b1);
    run_op("n11",  28'd11,        1, 11, 28'd39916800, 1'b0);

    // Abort a computation with an asynchronous reset.
    n        = 28'd8;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_ovf", 32'(ovrflow), 32'd0);
    check("abort_dout", 32'(d_out), 32'd0);
    repeat (2) step();
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      step();
      if (valid_out) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);

    run_op("n3", 28'd3, 1, 3, 28'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
